// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, defaults and helpers for the 8N1 receiver.
package uart_rx_pkg;

    // 3-bit receiver state encoding
    typedef enum logic [2:0] {
        UART_RX_WAIT_IDLE = 3'd0,
        UART_RX_IDLE      = 3'd1,
        UART_RX_START     = 3'd2,
        UART_RX_DATA      = 3'd3,
        UART_RX_STOP      = 3'd4
    } uart_rx_state_e;

    // 100 MHz / 115200 baud
    localparam int unsigned UART_RX_CLKS_PER_BIT_DEF = 868;

    // Counter value at which WAIT_IDLE accepts the line as idle. Three
    // consecutive high samples are needed so the reset value still sitting
    // in the synchronizer cannot pass for a real idle line.
    localparam int unsigned UART_RX_IDLE_SETTLE = 2;

    // 2-of-3 vote
    function automatic logic uart_rx_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for the async rx pin; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding the RAM loader.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of the
// samples at mid-1, mid, mid+1 (decision made at mid+1); otherwise a single
// sample at mid is used.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_RX_CLKS_PER_BIT_DEF,
    parameter int unsigned CTR_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       busy,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned DECIDE_DLY = 1;
`else
    localparam int unsigned DECIDE_DLY = 0;
`endif

    localparam logic [CTR_W-1:0] START_LAST  = CTR_W'(CLKS_PER_BIT / 2 - 1 + DECIDE_DLY);
    localparam logic [CTR_W-1:0] BIT_LAST    = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CTR_W-1:0] IDLE_SETTLE = CTR_W'(UART_RX_IDLE_SETTLE);

    uart_rx_state_e state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             busy_q, busy_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;
    logic             sample;

    uart_rx_sync u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Two previous synchronized samples for the 2-of-3 vote
    always_ff @(posedge clk) begin
        if (rst) hist_q <= '1;
        else     hist_q <= {hist_q[0], rx_s};
    end

    assign sample = uart_rx_maj3(hist_q[1], hist_q[0], rx_s);
`else
    assign sample = rx_s;
`endif

    // State, counter, shifter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UART_RX_WAIT_IDLE;
            ctr_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state and output logic for the frame FSM
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = ferr_q;

        unique case (state_q)
            UART_RX_WAIT_IDLE: begin
                // ctr counts consecutive high samples here
                if (!rx_s) begin
                    ctr_d = '0;
                end else if (ctr_q == IDLE_SETTLE) begin
                    state_d = UART_RX_IDLE;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            UART_RX_IDLE: begin
                if (!rx_s) begin
                    state_d = UART_RX_START;
                    ctr_d   = '0;
                end
            end
            UART_RX_START: begin
                if (ctr_q == START_LAST) begin
                    if (sample) begin
                        state_d = UART_RX_IDLE;
                    end else begin
                        busy_d    = 1'b1;
                        ctr_d     = '0;
                        bit_idx_d = '0;
                        state_d   = UART_RX_DATA;
                    end
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            UART_RX_DATA: begin
                if (ctr_q == BIT_LAST) begin
                    ctr_d   = '0;
                    shift_d = {sample, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = UART_RX_STOP;
                    else                   bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            UART_RX_STOP: begin
                if (ctr_q == BIT_LAST) begin
                    ctr_d  = '0;
                    data_d = shift_q;
                    busy_d = 1'b0;
                    if (sample) begin
                        valid_d = 1'b1;
                        state_d = UART_RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = UART_RX_WAIT_IDLE;
                    end
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            default: begin
                state_d = UART_RX_WAIT_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized 8N1 frames against a queue-based reference.
module tb_uart_rx;

    localparam int CPB = 64;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       busy;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .CTR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .busy      (busy),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    logic        rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Passive monitor: records every busy fall (data + valid) and busy rise time
    logic [7:0]  fall_data_q[$];
    logic        fall_valid_q[$];
    int unsigned rise_cyc_q[$];
    int          valid_count = 0;
    int          valid_wide  = 0;
    logic        busy_prev   = 1'b0;
    logic        valid_prev  = 1'b0;

    always @(negedge clk) begin
        if (!rst_seen) begin
            if (busy_prev && !busy) begin
                fall_data_q.push_back(data);
                fall_valid_q.push_back(valid);
            end
            if (!busy_prev && busy) rise_cyc_q.push_back(cyc);
            if (valid) valid_count++;
            if (valid && valid_prev) valid_wide++;
        end
        busy_prev  = busy;
        valid_prev = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame at pin level; optional 1-cycle high glitch and 1-cycle reset
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int glitch_at, input int rst_at);
        int   idx;
        logic v;
        for (int c = 0; c < 10 * CPB; c++) begin
            idx = c / CPB;
            if (idx == 0)      v = 1'b0;
            else if (idx <= 8) v = b[idx-1];
            else               v = stop_bit;
            if (c == glitch_at) v = 1'b1;
            rx  = v;
            rst = (c == rst_at);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic line(input logic lvl, input int n);
        rx = lvl;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Compare monitor records from index `from` against the expected frames
    task automatic check_frames(input string tag, input int from,
                                input logic [7:0] exp_d[$], input logic exp_v[$]);
        check({tag, "_nfalls"}, fall_data_q.size() - from, exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (from + i < fall_data_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), fall_data_q[from+i], exp_d[i]);
                check($sformatf("%s_valid%0d", tag, i), fall_valid_q[from+i], exp_v[i]);
            end
        end
    endtask

    int          n0, r0, vc0;
    int unsigned t0;
    logic [7:0]  ed[$];
    logic        ev[$];
    logic [7:0]  rb;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst = 1'b0;
        line(1'b1, 10);

        // 1: single frame, busy-rise latency = half bit + 2 sync + 1 register
        n0 = fall_data_q.size(); r0 = rise_cyc_q.size(); vc0 = valid_count; t0 = cyc;
        send_frame(8'hA5, 1'b1, -1, -1);
        line(1'b1, CPB);
        check("t1_nrise", rise_cyc_q.size() - r0, 1);
        if (rise_cyc_q.size() > r0)
            check("t1_rise_lat", rise_cyc_q[r0] - t0, CPB / 2 + 3 + MAJ);
        ed = '{8'hA5}; ev = '{1'b1};
        check_frames("t1", n0, ed, ev);
        check("t1_nvalid", valid_count - vc0, 1);
        check("t1_ferr", frame_err, 1'b0);

        // 2: back-to-back frames, no idle gap
        n0 = fall_data_q.size(); vc0 = valid_count;
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        send_frame(8'h55, 1'b1, -1, -1);
        line(1'b1, CPB);
        ed = '{8'h00, 8'hFF, 8'h55}; ev = '{1'b1, 1'b1, 1'b1};
        check_frames("t2", n0, ed, ev);
        check("t2_nvalid", valid_count - vc0, 3);

        // 3: low pulse shorter than half a bit is rejected; receiver re-arms
        n0 = fall_data_q.size(); r0 = rise_cyc_q.size(); vc0 = valid_count;
        line(1'b0, CPB / 4);
        line(1'b1, 2 * CPB);
        check("t3_nrise", rise_cyc_q.size() - r0, 0);
        check("t3_nvalid", valid_count - vc0, 0);
        send_frame(8'h5A, 1'b1, -1, -1);
        line(1'b1, CPB);
        ed = '{8'h5A}; ev = '{1'b1};
        check_frames("t3", n0, ed, ev);

        // 4: bad stop bit, long break, then a clean frame
        n0 = fall_data_q.size(); r0 = rise_cyc_q.size(); vc0 = valid_count;
        send_frame(8'h3C, 1'b0, -1, -1);
        line(1'b0, 2000);
        line(1'b1, CPB);
        check("t4_ferr_set", frame_err, 1'b1);
        send_frame(8'h12, 1'b1, -1, -1);
        line(1'b1, CPB);
        check("t4_nrise", rise_cyc_q.size() - r0, 2);
        ed = '{8'h3C, 8'h12}; ev = '{1'b0, 1'b1};
        check_frames("t4", n0, ed, ev);
        check("t4_nvalid", valid_count - vc0, 1);
        check("t4_ferr_sticky", frame_err, 1'b1);

        // 5: reset just after bit 4 of 0x81 while the line keeps going
        n0 = fall_data_q.size(); r0 = rise_cyc_q.size(); vc0 = valid_count;
        send_frame(8'h81, 1'b1, -1, 5 * CPB + CPB / 2 + 3);
        check("t5_busy", busy, 1'b0);
        check("t5_data", data, 8'h00);
        check("t5_ferr", frame_err, 1'b0);
        check("t5_nrise", rise_cyc_q.size() - r0, 1);
        check("t5_nvalid", valid_count - vc0, 0);
        line(1'b1, CPB);
        send_frame(8'h81, 1'b1, -1, -1);
        line(1'b1, CPB);
        ed = '{8'h81}; ev = '{1'b1};
        check_frames("t5", n0, ed, ev);

        // 6: 1-cycle high glitch at the middle of data bit 3
        n0 = fall_data_q.size();
        send_frame(8'h00, 1'b1, 4 * CPB + CPB / 2, -1);
        line(1'b1, CPB);
        ed = '{(MAJ != 0) ? 8'h00 : 8'h08}; ev = '{1'b1};
        check_frames("t6", n0, ed, ev);

        // 7: random bytes with random idle gaps (including zero)
        n0 = fall_data_q.size(); vc0 = valid_count;
        ed = {}; ev = {};
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom_range(0, 255));
            ed.push_back(rb);
            ev.push_back(1'b1);
            send_frame(rb, 1'b1, -1, -1);
            line(1'b1, int'($urandom_range(0, CPB)));
        end
        line(1'b1, CPB);
        check_frames("rand", n0, ed, ev);
        check("rand_nvalid", valid_count - vc0, 8);

        check("valid_width", valid_wide, 0);
        check("final_ferr", frame_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
